// File: rtl/conv_scheduler_pkg.sv
// Shared definitions for the convolution window scheduler: FSM state encoding
// and the expected number of strided windows per frame.
package conv_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Windows per frame; integer division truncates partial strides.
   function automatic int expected_count(input int width, input int height,
                                         input int filter, input int stride);
      return ((width - filter + 1) / stride) * ((height - filter + 1) / stride);
   endfunction

endpackage

// File: rtl/conv_scheduler_window_counter.sv
// Pixel x/y bookkeeping and strided-window detection for one raster frame.
// col/row report the last accepted pixel; window_valid is registered.
module window_counter #(
   parameter int IMAGE_WIDTH  = 64,
   parameter int IMAGE_HEIGHT = 32,
   parameter int FILTER_SIZE  = 5,
   parameter int STRIDE       = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clk_en,
   input  logic                            clear,
   input  logic                            accept,
   output logic [$clog2(IMAGE_WIDTH)-1:0]  col,
   output logic [$clog2(IMAGE_HEIGHT)-1:0] row,
   output logic                            window_valid,
   output logic                            last_pixel
);

   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam int NX = (IMAGE_WIDTH - FILTER_SIZE + 1) / STRIDE;
   localparam int NY = (IMAGE_HEIGHT - FILTER_SIZE + 1) / STRIDE;

   localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_HEIGHT - 1);
   localparam logic [CW-1:0] WIN_X0  = CW'(FILTER_SIZE - 1);
   localparam logic [RW-1:0] WIN_Y0  = RW'(FILTER_SIZE - 1);
   localparam logic [CW-1:0] WIN_XN  = CW'(FILTER_SIZE - 1 + STRIDE * (NX - 1));
   localparam logic [RW-1:0] WIN_YN  = RW'(FILTER_SIZE - 1 + STRIDE * (NY - 1));
   localparam logic [CW-1:0] X_STEP  = CW'(STRIDE);
   localparam logic [RW-1:0] Y_STEP  = RW'(STRIDE);

   // Position of the next pixel and of the next window-completing column/row.
   // win_x/win_y stop at the last counted window, so partial strides never hit.
   logic [CW-1:0] x_pos, win_x;
   logic [RW-1:0] y_pos, win_y;
   logic          row_end, hit;

   assign row_end    = (x_pos == COL_MAX);
   assign last_pixel = row_end && (y_pos == ROW_MAX);
   assign hit        = (x_pos == win_x) && (y_pos == win_y);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_pos        <= '0;
         y_pos        <= '0;
         win_x        <= WIN_X0;
         win_y        <= WIN_Y0;
         col          <= '0;
         row          <= '0;
         window_valid <= 1'b0;
      end else if (clk_en) begin
         if (clear) begin
            x_pos        <= '0;
            y_pos        <= '0;
            win_x        <= WIN_X0;
            win_y        <= WIN_Y0;
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
         end else begin
            window_valid <= accept && hit;
            if (accept) begin
               col <= x_pos;
               row <= y_pos;
               if (row_end) begin
                  x_pos <= '0;
                  win_x <= WIN_X0;
                  if (last_pixel) begin
                     y_pos <= '0;
                     win_y <= WIN_Y0;
                  end else begin
                     y_pos <= y_pos + RW'(1);
                     if ((y_pos == win_y) && (win_y != WIN_YN))
                        win_y <= win_y + Y_STEP;
                  end
               end else begin
                  x_pos <= x_pos + CW'(1);
                  if ((x_pos == win_x) && (win_x != WIN_XN))
                     win_x <= win_x + X_STEP;
               end
            end
         end
      end
   end

endmodule

// File: rtl/conv_scheduler.sv
// Frame scheduler for a strided convolution: accepts one raster frame of
// pixels, flags completed windows and waits for every datapath result.
module conv_scheduler
   import conv_scheduler_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 64,
   parameter int IMAGE_HEIGHT = 32,
   parameter int FILTER_SIZE  = 5,
   parameter int STRIDE       = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clk_en,
   input  logic                            start,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic                            window_valid,
   output logic [$clog2(IMAGE_WIDTH)-1:0]  col,
   output logic [$clog2(IMAGE_HEIGHT)-1:0] row,
   input  logic                            result_valid,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            overrun
);

   localparam int EXP_TOTAL = expected_count(IMAGE_WIDTH, IMAGE_HEIGHT, FILTER_SIZE, STRIDE);
   localparam int CNT_W     = $clog2(EXP_TOTAL + 1);
   localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_TOTAL);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] res_cnt, res_cnt_nxt;
   logic             accept, frame_start, counting, res_hit, res_over, last_pixel;

   assign accept      = in_valid & in_ready & clk_en;
   assign frame_start = (state == ST_IDLE) & start & clk_en;
   assign counting    = (state == ST_STREAM) | (state == ST_DRAIN);
   assign res_hit     = counting & result_valid & (res_cnt != EXP_CNT);
   assign res_over    = counting & result_valid & (res_cnt == EXP_CNT);

   window_counter #(
      .IMAGE_WIDTH  (IMAGE_WIDTH),
      .IMAGE_HEIGHT (IMAGE_HEIGHT),
      .FILTER_SIZE  (FILTER_SIZE),
      .STRIDE       (STRIDE)
   ) u_window_counter (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .clear        (frame_start),
      .accept       (accept),
      .col          (col),
      .row          (row),
      .window_valid (window_valid),
      .last_pixel   (last_pixel)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      res_cnt_nxt = res_hit ? res_cnt + CNT_W'(1) : res_cnt;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_STREAM;
         ST_STREAM: if (accept && last_pixel)
                       state_nxt = (res_cnt_nxt == EXP_CNT) ? ST_DONE : ST_DRAIN;
         ST_DRAIN:  if (res_cnt_nxt == EXP_CNT) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they stay registered yet
   // line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         res_cnt    <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else if (clk_en) begin
         state      <= state_nxt;
         res_cnt    <= frame_start ? '0 : res_cnt_nxt;
         in_ready   <= (state_nxt == ST_STREAM);
         busy       <= (state_nxt != ST_IDLE);
         frame_done <= (state_nxt == ST_DONE);
         if (frame_start)
            overrun <= 1'b0;
         else if (res_over)
            overrun <= 1'b1;
      end
   end

endmodule
